// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: holds the PC, issues a level read request and latches the returned word.
// Optional REQ-state watchdog compiled in with `define FETCH_TIMEOUT_EN.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_ADDR     = 32'h0000_0000,
  parameter int          TIMEOUT_CYCLES = 16
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        PCWre,
  input  logic [31:0] newAddress,
  output logic [31:0] currentAddress,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [25:0] jAddress,
  output logic [31:0] outData,
  output logic        addr_misaligned,
  output logic        fetch_err
);

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be in 2..255");
  end
  if (RESET_ADDR[1:0] != 2'b00) begin : g_bad_reset_addr
    $error("RESET_ADDR must be word aligned");
  end

  typedef enum logic [1:0] {S_REQ, S_HOLD, S_ERR} state_e;

  state_e      state_q;
  logic [31:0] pc_q;
  logic [31:0] instr_q;
  logic        req_q;
  logic        valid_q;
  logic        mis_q;
  logic        err_q;

`ifdef FETCH_TIMEOUT_EN
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] cnt_q;
`endif

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q <= S_REQ;
      pc_q    <= RESET_ADDR;
      instr_q <= '0;
      req_q   <= 1'b1;
      valid_q <= 1'b0;
      mis_q   <= 1'b0;
      err_q   <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      mis_q <= 1'b0;
      case (state_q)
        S_REQ: begin
          if (imem_ack) begin
            instr_q <= imem_rdata;
            state_q <= S_HOLD;
            req_q   <= 1'b0;
            valid_q <= 1'b1;
`ifdef FETCH_TIMEOUT_EN
          end else if (cnt_q == CNT_LAST) begin
            state_q <= S_ERR;
            req_q   <= 1'b0;
            err_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 8'd1;
`endif
          end
        end
        S_HOLD: begin
          if (PCWre) begin
            pc_q    <= {newAddress[31:2], 2'b00};
            state_q <= S_REQ;
            req_q   <= 1'b1;
            valid_q <= 1'b0;
            mis_q   <= |newAddress[1:0];
`ifdef FETCH_TIMEOUT_EN
            cnt_q   <= '0;
`endif
          end
        end
        S_ERR: ;  // only Reset leaves the error state
        default: begin
          state_q <= S_REQ;
          req_q   <= 1'b1;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  // The request is masked while Reset is held so nothing is issued before release.
  assign imem_req        = req_q & ~Reset;
  assign currentAddress  = pc_q;
  assign imem_addr       = pc_q;
  assign instr_valid     = valid_q;
  assign instr           = instr_q;
  assign jAddress        = instr_q[25:0];
  assign outData         = {{16{instr_q[15]}}, instr_q[15:0]};
  assign addr_misaligned = mis_q;
`ifdef FETCH_TIMEOUT_EN
  assign fetch_err       = err_q;
`else
  assign fetch_err       = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomised self-checking bench for instr_fetch_unit against a PC/instruction reference model.
module tb_instr_fetch_unit;

  localparam int T = 16;

  logic        CLK = 1'b0;
  logic        Reset, PCWre, imem_ack;
  logic [31:0] newAddress, imem_rdata;
  logic [31:0] currentAddress, imem_addr, instr, outData;
  logic [25:0] jAddress;
  logic        imem_req, instr_valid, addr_misaligned, fetch_err;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_pc, exp_instr;

  always #5 CLK = ~CLK;

  instr_fetch_unit #(.RESET_ADDR(32'h0000_0000), .TIMEOUT_CYCLES(T)) dut (
    .CLK(CLK), .Reset(Reset), .PCWre(PCWre), .newAddress(newAddress),
    .currentAddress(currentAddress), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr_valid(instr_valid),
    .instr(instr), .jAddress(jAddress), .outData(outData),
    .addr_misaligned(addr_misaligned), .fetch_err(fetch_err)
  );

  function automatic logic [31:0] sext16(input logic [31:0] w);
    logic signed [15:0] h;
    h = w[15:0];
    return 32'(int'(h));
  endfunction

  task automatic tick;
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic test_reset;
    Reset = 1'b1; PCWre = 1'b1; newAddress = $urandom; imem_ack = 1'b1; imem_rdata = $urandom;
    tick; tick;
    checks++;
    if (currentAddress !== 32'h0 || instr !== 32'h0 || instr_valid !== 1'b0 || imem_req !== 1'b0 ||
        addr_misaligned !== 1'b0 || fetch_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: pc=%h instr=%h valid=%b req=%b mis=%b err=%b expected pc=0 instr=0 all flags 0",
               currentAddress, instr, instr_valid, imem_req, addr_misaligned, fetch_err);
    end
    Reset = 1'b0; PCWre = 1'b0; imem_ack = 1'b0;
    #1;
    checks++;
    if (imem_req !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_req: imem_req=%b expected 1", imem_req);
    end
    exp_pc = 32'h0; exp_instr = 32'h0;
  endtask

  // Wait `delay` REQ cycles, then ack with `data`; optional PCWre noise must be ignored.
  task automatic fetch(input int delay, input logic [31:0] data, input bit noise, input string tag);
    for (int i = 0; i < delay; i++) begin
      PCWre = noise ? 1'($urandom) : 1'b0; newAddress = $urandom;
      imem_ack = 1'b0; imem_rdata = $urandom;
      tick;
      checks++;
      if (imem_req !== 1'b1 || instr_valid !== 1'b0 || currentAddress !== exp_pc ||
          imem_addr !== exp_pc || addr_misaligned !== 1'b0 || fetch_err !== 1'b0) begin
        errors++;
        $display("FAIL %s_wait: req=%b valid=%b pc=%h addr=%h mis=%b err=%b expected req=1 valid=0 pc=addr=%h mis=0 err=0",
                 tag, imem_req, instr_valid, currentAddress, imem_addr, addr_misaligned, fetch_err, exp_pc);
      end
    end
    PCWre = noise ? 1'($urandom) : 1'b0; newAddress = $urandom;
    imem_ack = 1'b1; imem_rdata = data;
    tick;
    exp_instr = data;
    PCWre = 1'b0; imem_ack = 1'b0;
    checks++;
    if (instr_valid !== 1'b1 || imem_req !== 1'b0 || instr !== exp_instr || currentAddress !== exp_pc ||
        addr_misaligned !== 1'b0) begin
      errors++;
      $display("FAIL %s_capture: valid=%b req=%b instr=%h pc=%h mis=%b expected valid=1 req=0 instr=%h pc=%h mis=0",
               tag, instr_valid, imem_req, instr, currentAddress, addr_misaligned, exp_instr, exp_pc);
    end
    checks++;
    if (jAddress !== exp_instr[25:0] || outData !== sext16(exp_instr)) begin
      errors++;
      $display("FAIL %s_decode: jAddress=%h outData=%h expected %h %h",
               tag, jAddress, outData, exp_instr[25:0], sext16(exp_instr));
    end
    // Stray acks while holding must not disturb the latched word.
    for (int i = 0; i < 2; i++) begin
      imem_ack = 1'($urandom); imem_rdata = $urandom;
      tick;
      checks++;
      if (instr_valid !== 1'b1 || instr !== exp_instr || currentAddress !== exp_pc) begin
        errors++;
        $display("FAIL %s_hold: valid=%b instr=%h pc=%h expected 1 %h %h",
                 tag, instr_valid, instr, currentAddress, exp_instr, exp_pc);
      end
    end
    imem_ack = 1'b0;
  endtask

  task automatic advance(input logic [31:0] addr, input string tag);
    logic exp_mis;
    PCWre = 1'b1; newAddress = addr; imem_ack = 1'b0;
    tick;
    PCWre = 1'b0;
    exp_pc  = addr & 32'hFFFF_FFFC;
    exp_mis = (addr % 4) != 0;
    checks++;
    if (currentAddress !== exp_pc || imem_addr !== exp_pc || imem_req !== 1'b1 ||
        instr_valid !== 1'b0 || addr_misaligned !== exp_mis) begin
      errors++;
      $display("FAIL %s_advance: pc=%h addr=%h req=%b valid=%b mis=%b expected pc=%h req=1 valid=0 mis=%b",
               tag, currentAddress, imem_addr, imem_req, instr_valid, addr_misaligned, exp_pc, exp_mis);
    end
  endtask

  task automatic test_basic;
    fetch(1, 32'h0800_0010, 1'b0, "basic");
    checks++;
    if (imem_addr !== 32'h0 || jAddress !== 26'h10 || outData !== 32'h10) begin
      errors++;
      $display("FAIL basic_vector: addr=%h jAddress=%h outData=%h expected 0 10 10", imem_addr, jAddress, outData);
    end
  endtask

  task automatic test_misaligned;
    advance(32'h0000_0042, "mis");
    checks++;
    if (currentAddress !== 32'h40) begin
      errors++;
      $display("FAIL mis_pc: pc=%h expected 00000040", currentAddress);
    end
    fetch(0, 32'h2108_FFFC, 1'b0, "sext");
    checks++;
    if (outData !== 32'hFFFF_FFFC) begin
      errors++;
      $display("FAIL sext_vector: outData=%h expected fffffffc", outData);
    end
  endtask

  task automatic test_wait_pcwre;
    advance(32'h0000_1000, "wait");
    fetch(5, $urandom, 1'b1, "wait");
  endtask

  task automatic test_wraparound;
    advance(32'hFFFF_FFFF, "wrap");
    fetch(2, $urandom, 1'b0, "wrap");
  endtask

  task automatic test_random;
    for (int n = 0; n < 25; n++) begin
      advance($urandom, "rand");
      fetch(int'($urandom_range(0, 12)), $urandom, 1'b1, "rand");
    end
  endtask

  task automatic test_timeout;
    // The ack arriving on the last permitted cycle must still be accepted.
    advance(32'h0000_0200, "edge");
    fetch(T - 1, $urandom, 1'b0, "edge");
`ifdef FETCH_TIMEOUT_EN
    advance(32'h0000_0300, "tmo");
    for (int i = 1; i < T; i++) begin
      imem_ack = 1'b0;
      tick;
      checks++;
      if (imem_req !== 1'b1 || fetch_err !== 1'b0) begin
        errors++;
        $display("FAIL tmo_early cycle %0d: req=%b err=%b expected 1 0", i, imem_req, fetch_err);
      end
    end
    tick;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (fetch_err !== 1'b1 || imem_req !== 1'b0 || instr_valid !== 1'b0) begin
        errors++;
        $display("FAIL tmo_err cycle %0d: err=%b req=%b valid=%b expected 1 0 0", i, fetch_err, imem_req, instr_valid);
      end
      imem_ack = 1'b1; PCWre = 1'b1; newAddress = $urandom;
      tick;
    end
    imem_ack = 1'b0; PCWre = 1'b0;
    test_reset;
    fetch(1, $urandom, 1'b0, "post_err");
`else
    advance(32'h0000_0300, "nowdt");
    fetch(3 * T, $urandom, 1'b0, "nowdt");
`endif
  endtask

  task automatic test_reset_in_hold;
    advance(32'h0000_0500, "rih");
    fetch(1, $urandom, 1'b0, "rih");
    Reset = 1'b1; PCWre = 1'b1; newAddress = 32'h0000_0743; imem_ack = 1'b1;
    tick;
    checks++;
    if (currentAddress !== 32'h0 || instr_valid !== 1'b0 || addr_misaligned !== 1'b0 || instr !== 32'h0) begin
      errors++;
      $display("FAIL reset_in_hold: pc=%h valid=%b mis=%b instr=%h expected 0 0 0 0",
               currentAddress, instr_valid, addr_misaligned, instr);
    end
    Reset = 1'b0; PCWre = 1'b0; imem_ack = 1'b0;
    exp_pc = 32'h0; exp_instr = 32'h0;
    tick;
    checks++;
    if (addr_misaligned !== 1'b0 || imem_req !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_hold_after: mis=%b req=%b expected 0 1", addr_misaligned, imem_req);
    end
    fetch(2, $urandom, 1'b0, "after_rih");
  endtask

  initial begin
    Reset = 1'b1; PCWre = 1'b0; newAddress = '0; imem_ack = 1'b0; imem_rdata = '0;
    @(negedge CLK);
    test_reset;
    test_basic;
    test_misaligned;
    test_wait_pcwre;
    test_wraparound;
    test_random;
    test_timeout;
    test_reset_in_hold;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
